// File: rtl/video_capture_pkg.sv
// rtl/video_capture_pkg.sv - shared capture/display types: FSM encoding, RGB565 layout, default geometry
package video_capture_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;
    localparam int PIX_W        = 16;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_SKIP    = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_e;

    // RGB565 field layout: [15:11] R, [10:5] G, [4:0] B
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/pix_pack.sv
// rtl/pix_pack.sv - packs pairs of 16-bit pixels into 32-bit words, flushing a lone pixel with a zero low half
module pix_pack
    import video_capture_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              pix_valid,
    input  rgb565_t           pix_data,
    input  logic              flush,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              half
);

    rgb565_t hi_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_pix     <= '0;
            half       <= 1'b0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            half       <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (pix_valid && !half) begin
                hi_pix <= pix_data;
                half   <= 1'b1;
            end else if (pix_valid && half) begin
                word_data  <= {hi_pix, pix_data};
                word_valid <= 1'b1;
                half       <= 1'b0;
            end else if (flush && half) begin
                word_data  <= {hi_pix, {PIX_W{1'b0}}};
                word_valid <= 1'b1;
                half       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_capture.sv
// rtl/video_capture.sv - RGB565 camera capture: frame sync, skip frames, pixel-pair packing to DDR writes
module video_capture
    import video_capture_pkg::*;
#(
    parameter int H_ActivePix = H_ACTIVE_DEF,
    parameter int V_ActivePix = V_ACTIVE_DEF,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              cap_clk,
    input  logic              cap_rst_n,
    input  logic              ddr_init_done,
    input  logic              cap_vsync,
    input  logic              cap_de,
    input  logic [PIX_W-1:0]  cap_data,
    input  logic              ddr_wr_full,
    output logic [WORD_W-1:0] ddr_data,
    output logic              ddr_wren,
    output logic              ddr_addr_set,
    output logic              cap_framesync,
    output logic              frame_done,
    output logic              overflow_err,
    output logic              frame_err
);

    localparam int PW = $clog2(H_ActivePix + 2);
    localparam int LW = $clog2(V_ActivePix + 1);
    localparam int SW = $clog2(SKIP_FRAMES + 2);

    cap_state_e    state, state_nxt;
    logic [SW-1:0] skip_cnt, skip_nxt;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic          vsync_q, de_q;
    logic          frame_start, line_end, capturing, restart, last_line;
    logic          take_pix, pack_clear, word_valid, pack_half, done_wait;

    assign cap_framesync = vsync_q;
    assign frame_start   = vsync_q & ~cap_vsync;
    assign line_end      = de_q & ~cap_de;
    assign capturing     = (state == ST_CAPTURE) & ddr_init_done;
    assign restart       = frame_start & (state_nxt == ST_CAPTURE);
    assign last_line     = capturing & line_end & ~frame_start
                         & (line_cnt == LW'(V_ActivePix - 1));
    assign take_pix      = capturing & cap_de & (pix_cnt < PW'(H_ActivePix));
    assign pack_clear    = ~ddr_init_done | restart;
    // a full FIFO swallows the word outright; nothing is retried
    assign ddr_wren      = word_valid & ~ddr_wr_full;

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (!ddr_init_done) begin
            state_nxt = ST_IDLE;
            skip_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    skip_nxt  = '0;
                    state_nxt = ST_SYNC;
                end
                ST_SYNC: begin
                    if (frame_start)
                        state_nxt = (skip_cnt < SW'(SKIP_FRAMES)) ? ST_SKIP : ST_CAPTURE;
                end
                ST_SKIP: begin
                    if (frame_start) begin
                        if (skip_cnt < SW'(SKIP_FRAMES))
                            skip_nxt = skip_cnt + 1'b1;
                        state_nxt = (skip_nxt < SW'(SKIP_FRAMES)) ? ST_SKIP : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (last_line)
                        state_nxt = ST_SYNC;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cap_clk or negedge cap_rst_n) begin
        if (!cap_rst_n) begin
            state        <= ST_IDLE;
            skip_cnt     <= '0;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            ddr_addr_set <= 1'b0;
            frame_done   <= 1'b0;
            done_wait    <= 1'b0;
            overflow_err <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            skip_cnt     <= skip_nxt;
            vsync_q      <= cap_vsync;
            de_q         <= cap_de;
            ddr_addr_set <= restart;
            frame_done   <= done_wait;
            done_wait    <= 1'b0;

            if (!capturing || restart) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (line_end) begin
                pix_cnt  <= '0;
                line_cnt <= line_cnt + 1'b1;
            end else if (cap_de && pix_cnt != '1) begin
                pix_cnt  <= pix_cnt + 1'b1;
            end

            if (capturing && (frame_start || (line_end && pix_cnt != PW'(H_ActivePix))))
                frame_err <= 1'b1;
            if (word_valid && ddr_wr_full)
                overflow_err <= 1'b1;

            // a pending half pair is flushed one cycle later, so frame_done waits for it
            if (last_line) begin
                if (pack_half)
                    done_wait <= 1'b1;
                else
                    frame_done <= 1'b1;
            end
        end
    end

    pix_pack u_pix_pack (
        .clk        (cap_clk),
        .rst_n      (cap_rst_n),
        .clear      (pack_clear),
        .pix_valid  (take_pix),
        .pix_data   (rgb565_t'(cap_data)),
        .flush      (capturing & line_end),
        .word_data  (ddr_data),
        .word_valid (word_valid),
        .half       (pack_half)
    );

endmodule
